// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS Montgomery multiplier and its result collector.
// The latency defaults match the multiplier's PE_DELAY derivation.
package fios_pkg;

    localparam int FIOS_WORD_WIDTH_DEF    = 17;
    localparam int FIOS_S_DEF             = 8;
    localparam int FIOS_START_LATENCY_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE,
        ST_VALID
    } state_e;

    // Bit offset of word k inside a packed multi-word value.
    function automatic int word_offset(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/fios_word_sub.sv
// Single-word subtract with borrow in/out, one slice of a word-serial a - b.
module fios_word_sub #(
    parameter int W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         borrow_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] d;

    // The extra top bit goes negative exactly when a borrow leaves this word.
    assign d        = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
    assign diff_o   = d[W-1:0];
    assign borrow_o = d[W];

endmodule

// File: rtl/fios_res_collector.sv
// Collects the FIOS RES word stream into a packed result behind a valid/ready handshake.
// Define FIOS_FINAL_SUB_EN to apply the final conditional subtraction of p on the fly.
module fios_res_collector
    import fios_pkg::*;
#(
    parameter int WORD_WIDTH    = FIOS_WORD_WIDTH_DEF,
    parameter int s             = FIOS_S_DEF,
    parameter int START_LATENCY = FIOS_START_LATENCY_DEF
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    start_i,
    input  logic [WORD_WIDTH-1:0]   res_word_i,
    input  logic [s*WORD_WIDTH-1:0] p_i,
    output logic                    busy_o,
    output logic [s*WORD_WIDTH-1:0] res_o,
    output logic                    res_valid_o,
    input  logic                    res_ready_i
);

    localparam int RW    = s * WORD_WIDTH;
    localparam int LAT_W = $clog2(START_LATENCY + 1);
    localparam int CNT_W = $clog2(s + 1);

    state_e           state_q;
    logic [LAT_W-1:0] lat_q;
    logic [CNT_W-1:0] wcnt_q;
    logic             busy_q;
    logic             valid_q;
    logic [RW-1:0]    res_q;
    logic [RW-1:0]    words_q;
    logic [RW-1:0]    words_d;
    logic [RW-1:0]    result_d;
    int               off;

    assign off = word_offset(int'(wcnt_q), WORD_WIDTH);

    always_comb begin
        words_d                        = words_q;
        words_d[off +: WORD_WIDTH]     = res_word_i;
    end

`ifdef FIOS_FINAL_SUB_EN
    logic [RW-1:0]         diff_q;
    logic [RW-1:0]         diff_d;
    logic [WORD_WIDTH-1:0] dword;
    logic                  borrow_q;
    logic                  borrow_nx;

    fios_word_sub #(.W(WORD_WIDTH)) u_word_sub (
        .a_i      (res_word_i),
        .b_i      (p_i[off +: WORD_WIDTH]),
        .borrow_i (borrow_q),
        .diff_o   (dword),
        .borrow_o (borrow_nx)
    );

    always_comb begin
        diff_d                    = diff_q;
        diff_d[off +: WORD_WIDTH] = dword;
    end

    // Borrow sits at zero outside CAPTURE, so every capture starts clean.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            borrow_q <= 1'b0;
        else if (state_q == ST_CAPTURE)
            borrow_q <= borrow_nx;
        else
            borrow_q <= 1'b0;
    end

    always_ff @(posedge clock_i) begin
        if (state_q == ST_CAPTURE)
            diff_q <= diff_d;
    end

    // No borrow out of the top word means result >= p: take the difference.
    assign result_d = borrow_nx ? words_d : diff_d;
`else
    logic unused_p;
    assign unused_p = ^p_i;
    assign result_d = words_d;
`endif

    always_ff @(posedge clock_i) begin
        if (state_q == ST_CAPTURE)
            words_q <= words_d;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        wcnt_q <= '0;
                        if (START_LATENCY == 1) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            state_q <= ST_WAIT;
                            lat_q   <= LAT_W'(START_LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    lat_q <= lat_q - LAT_W'(1);
                    if (lat_q == LAT_W'(1))
                        state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    wcnt_q <= wcnt_q + CNT_W'(1);
                    if (wcnt_q == CNT_W'(s - 1)) begin
                        state_q <= ST_VALID;
                        valid_q <= 1'b1;
                        res_q   <= result_d;
                    end
                end
                ST_VALID: begin
                    if (res_ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign res_valid_o = valid_q;
    assign res_o       = res_q;

endmodule

// File: tb/tb_fios_res_collector.sv
// Scoreboard bench for fios_res_collector (WORD_WIDTH=17, s=2, START_LATENCY=3).
module tb_fios_res_collector;

    localparam int W  = 17;
    localparam int S  = 2;
    localparam int L  = 3;
    localparam int RW = S * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  res_word;
    logic [RW-1:0] p;
    logic          busy;
    logic [RW-1:0] res;
    logic          res_valid;
    logic          res_ready;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];

    fios_res_collector #(
        .WORD_WIDTH    (W),
        .s             (S),
        .START_LATENCY (L)
    ) dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .start_i     (start),
        .res_word_i  (res_word),
        .p_i         (p),
        .busy_o      (busy),
        .res_o       (res),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result %0h with nothing expected", res);
            end else begin
                chk("sb_result", 64'(res), 64'(exp_q.pop_front()));
            end
        end
    end

    // Issues start at cycle 0 and feeds words at cycles 3 and 4; returns in cycle 5.
    task automatic start_and_feed(input logic [W-1:0] w0, input logic [W-1:0] w1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        tick();
        tick();
        res_word = w0;
        tick();
        res_word = w1;
        chk("valid_before_c5", 64'(res_valid), 64'(0));
        tick();
        res_word = '0;
    endtask

    initial begin
        logic [RW-1:0] e;
        rst_n     = 1'b0;
        start     = 1'b0;
        res_word  = '0;
        p         = '0;
        res_ready = 1'b0;

        #12;
        chk("rst_busy",  64'(busy),      64'(0));
        chk("rst_valid", 64'(res_valid), 64'(0));
        chk("rst_res",   64'(res),       64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic capture, ready held high.
        res_ready = 1'b1;
        exp_q.push_back({17'h1ABCD, 17'h00005});
        start_and_feed(17'h00005, 17'h1ABCD);
        chk("basic_valid_c5", 64'(res_valid), 64'(1));
        chk("basic_res_c5",   64'(res), 64'({17'h1ABCD, 17'h00005}));
        tick();
        chk("basic_busy_c6",  64'(busy),      64'(0));
        chk("basic_valid_c6", 64'(res_valid), 64'(0));
        tick();

        // Backpressure with a stray start in cycle 7.
        res_ready = 1'b0;
        e = {17'h0F0F0, 17'h10101};
        exp_q.push_back(e);
        start_and_feed(17'h10101, 17'h0F0F0);
        for (int c = 5; c <= 9; c++) begin
            chk("bp_valid", 64'(res_valid), 64'(1));
            chk("bp_res",   64'(res),       64'(e));
            start     = (c == 7);
            res_ready = (c == 9);
            tick();
        end
        start = 1'b0;
        chk("bp_busy_c10",  64'(busy),      64'(0));
        chk("bp_valid_c10", 64'(res_valid), 64'(0));
        for (int c = 0; c < 10; c++) begin
            chk("bp_no_second", 64'(res_valid | busy), 64'(0));
            tick();
        end

        // Back-to-back: start on the handshake cycle ignored, next cycle accepted.
        res_ready = 1'b1;
        exp_q.push_back({17'h00002, 17'h00001});
        start_and_feed(17'h00001, 17'h00002);
        chk("b2b_valid_c5", 64'(res_valid), 64'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy_c6", 64'(busy), 64'(0));
        e = {17'h00AAA, 17'h15555};
        exp_q.push_back(e);
        start_and_feed(17'h15555, 17'h00AAA);
        chk("b2b_valid_c11", 64'(res_valid), 64'(1));
        chk("b2b_res_c11",   64'(res),       64'(e));
        tick();
        chk("b2b_busy_c12", 64'(busy), 64'(0));
        tick();

        // Reset in the middle of CAPTURE.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        res_word = 17'h01234;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(busy),      64'(0));
        chk("mid_rst_valid", 64'(res_valid), 64'(0));
        chk("mid_rst_res",   64'(res),       64'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        res_word = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("mid_rst_no_valid", 64'(res_valid | busy), 64'(0));
        end
        exp_q.push_back({17'h00077, 17'h00066});
        start_and_feed(17'h00066, 17'h00077);
        chk("post_rst_valid", 64'(res_valid), 64'(1));
        tick();
        tick();

        // Final subtraction cases; without the feature the raw words come through.
        p = {17'h00001, 17'h00010};
`ifdef FIOS_FINAL_SUB_EN
        e = {17'h00000, 17'h1FFF5};
`else
        e = {17'h00002, 17'h00005};
`endif
        exp_q.push_back(e);
        start_and_feed(17'h00005, 17'h00002);
        chk("sub_ge_res", 64'(res), 64'(e));
        tick();
        tick();
        e = {17'h00000, 17'h00005};
        exp_q.push_back(e);
        start_and_feed(17'h00005, 17'h00000);
        chk("sub_lt_res", 64'(res), 64'(e));
        tick();
        tick();

        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
